// File: rtl/ex_stage_md.sv
// Execute stage for the R/I/J pipeline: ALU, branch/jump condition, flags and EX/MEM registers,
// plus an iterative one-bit-per-cycle multiply/divide unit with HI/LO and a decode interlock.
module ex_stage_md #(
    parameter int              XLEN              = 32,
    parameter logic [XLEN-1:0] MD_SIGNED_DIV0_LO = '1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [31:0]     IRi,
    input  logic [XLEN-1:0] NPCi,
    input  logic [XLEN-1:0] Ai,
    input  logic [XLEN-1:0] Bi,
    input  logic [XLEN-1:0] Immi,
    output logic            stall_o,
    output logic            out_valid,
    output logic            cond,
    output logic [XLEN-1:0] ALUo,
    output logic            ZFo,
    output logic            OFo,
    output logic [XLEN-1:0] Bo,
    output logic [31:0]     IRo
);
    localparam int CW = $clog2(XLEN);

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    md_state_t           r_md_state;
    md_state_t           w_md_state_next;
    logic [CW-1:0]       r_md_cnt;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     r_md_acc;
    logic [XLEN-1:0]     r_md_lo;
    logic [XLEN-1:0]     r_md_m;
    logic [XLEN-1:0]     r_md_dvd;
    logic                r_md_div;
    logic                r_md_div0;
    logic                r_md_neg_q;
    logic                r_md_neg_r;

    logic                r_out_valid;
    logic                r_cond;
    logic [XLEN-1:0]     r_alu;
    logic                r_zf;
    logic                r_of;
    logic [XLEN-1:0]     r_b;
    logic [31:0]         r_ir;

    logic [5:0]          w_op;
    logic [5:0]          w_funct;
    logic [4:0]          w_shamt;
    logic                w_is_mdop;
    logic                w_is_mf;
    logic                w_md_busy;
    logic                w_accept;
    logic                w_md_start;
    logic                w_md_done;
    logic [XLEN-1:0]     w_sum;
    logic [XLEN-1:0]     w_diff;
    logic [XLEN-1:0]     w_addi;
    logic [XLEN-1:0]     w_zimm;
    logic [XLEN-1:0]     w_lui;
    logic [XLEN-1:0]     w_alu;
    logic                w_cond;
    logic                w_of;

    assign w_op      = IRi[31:26];
    assign w_funct   = IRi[5:0];
    assign w_shamt   = IRi[10:6];
    assign w_is_mdop = (w_op == OP_R) && (w_funct[5:2] == 4'b0110);
    assign w_is_mf   = (w_op == OP_R) && ((w_funct == F_MFHI) || (w_funct == F_MFLO));
    assign w_md_busy = (r_md_state == MD_BUSY);

    // Only instructions that touch HI/LO wait for the MD unit; everything else flows past it.
    assign stall_o    = in_valid && w_md_busy && (w_is_mdop || w_is_mf);
    assign w_accept   = in_valid && !stall_o && !flush;
    assign w_md_start = w_accept && w_is_mdop;

    assign w_sum  = Ai + Bi;
    assign w_diff = Ai - Bi;
    assign w_addi = Ai + Immi;
    assign w_zimm = XLEN'(IRi[15:0]);
    assign w_lui  = XLEN'($signed({IRi[15:0], 16'h0000}));

    always_comb begin
        w_alu  = '0;
        w_cond = 1'b0;
        w_of   = 1'b0;
        case (w_op)
            OP_R: begin
                case (w_funct)
                    F_ADD: begin
                        w_alu = w_sum;
                        w_of  = (Ai[XLEN-1] == Bi[XLEN-1]) && (w_sum[XLEN-1] != Ai[XLEN-1]);
                    end
                    F_ADDU: w_alu = w_sum;
                    F_SUB: begin
                        w_alu = w_diff;
                        w_of  = (Ai[XLEN-1] != Bi[XLEN-1]) && (w_diff[XLEN-1] != Ai[XLEN-1]);
                    end
                    F_SUBU: w_alu = w_diff;
                    F_AND:  w_alu = Ai & Bi;
                    F_OR:   w_alu = Ai | Bi;
                    F_XOR:  w_alu = Ai ^ Bi;
                    F_NOR:  w_alu = ~(Ai | Bi);
                    F_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(Ai) < $signed(Bi))};
                    F_SLTU: w_alu = {{(XLEN-1){1'b0}}, (Ai < Bi)};
                    F_SLL:  w_alu = Bi << w_shamt;
                    F_SRL:  w_alu = Bi >> w_shamt;
                    F_SRA:  w_alu = $signed(Bi) >>> w_shamt;
                    F_MFHI: w_alu = r_hi;
                    F_MFLO: w_alu = r_lo;
                    default: w_alu = '0;
                endcase
            end
            OP_ADDI: begin
                w_alu = w_addi;
                w_of  = (Ai[XLEN-1] == Immi[XLEN-1]) && (w_addi[XLEN-1] != Ai[XLEN-1]);
            end
            OP_ADDIU, OP_LW, OP_SW: w_alu = w_addi;
            OP_SLTI: w_alu = {{(XLEN-1){1'b0}}, ($signed(Ai) < $signed(Immi))};
            OP_ANDI: w_alu = Ai & w_zimm;
            OP_ORI:  w_alu = Ai | w_zimm;
            OP_XORI: w_alu = Ai ^ w_zimm;
            OP_LUI:  w_alu = w_lui;
            OP_BEQ, OP_BNE: begin
                w_cond = (Ai == Bi) ^ (w_op == OP_BNE);
                w_alu  = NPCi + {Immi[XLEN-3:0], 2'b00};
            end
            OP_J, OP_JAL: begin
                w_cond = 1'b1;
                w_alu  = {NPCi[XLEN-1:28], IRi[25:0], 2'b00};
            end
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || !w_accept) begin
            r_out_valid <= 1'b0;
            r_cond      <= 1'b0;
            r_alu       <= '0;
            r_zf        <= 1'b0;
            r_of        <= 1'b0;
            r_b         <= '0;
            r_ir        <= '0;
        end else begin
            r_out_valid <= 1'b1;
            r_cond      <= w_cond;
            r_alu       <= w_alu;
            r_zf        <= (w_alu == '0);
            r_of        <= w_of;
            r_b         <= Bi;
            r_ir        <= IRi;
        end
    end

    assign out_valid = r_out_valid;
    assign cond      = r_cond;
    assign ALUo      = r_alu;
    assign ZFo       = r_zf;
    assign OFo       = r_of;
    assign Bo        = r_b;
    assign IRo       = r_ir;

    // MD unit works on magnitudes; signs are reapplied when the final step writes HI/LO.
    logic                w_sgn;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_rs;
    logic                w_ge;
    logic [XLEN-1:0]     w_rs_sub;
    logic [XLEN-1:0]     w_acc_next;
    logic [XLEN-1:0]     w_lo_next;
    logic [2*XLEN-1:0]   w_prod_mag;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_hi_res;
    logic [XLEN-1:0]     w_lo_res;

    assign w_sgn   = ~w_funct[0];
    assign w_a_neg = w_sgn && Ai[XLEN-1];
    assign w_b_neg = w_sgn && Bi[XLEN-1];
    assign w_a_mag = w_a_neg ? -Ai : Ai;
    assign w_b_mag = w_b_neg ? -Bi : Bi;

    assign w_mul_sum = {1'b0, r_md_acc} + (r_md_lo[0] ? {1'b0, r_md_m} : {(XLEN+1){1'b0}});
    assign w_rs      = {r_md_acc, r_md_lo[XLEN-1]};
    assign w_ge      = (w_rs >= {1'b0, r_md_m});
    assign w_rs_sub  = w_rs[XLEN-1:0] - r_md_m;

    always_comb begin
        if (r_md_div) begin
            w_acc_next = w_ge ? w_rs_sub : w_rs[XLEN-1:0];
            w_lo_next  = {r_md_lo[XLEN-2:0], w_ge};
        end else begin
            w_acc_next = w_mul_sum[XLEN:1];
            w_lo_next  = {w_mul_sum[0], r_md_lo[XLEN-1:1]};
        end
    end

    assign w_prod_mag = {w_acc_next, w_lo_next};
    assign w_prod     = r_md_neg_q ? -w_prod_mag : w_prod_mag;

    always_comb begin
        w_hi_res = w_prod[2*XLEN-1:XLEN];
        w_lo_res = w_prod[XLEN-1:0];
        if (r_md_div) begin
            if (r_md_div0) begin
                w_hi_res = r_md_dvd;
                w_lo_res = MD_SIGNED_DIV0_LO;
            end else begin
                w_hi_res = r_md_neg_r ? -w_acc_next : w_acc_next;
                w_lo_res = r_md_neg_q ? -w_lo_next : w_lo_next;
            end
        end
    end

    always_comb begin
        w_md_state_next = r_md_state;
        w_md_done       = 1'b0;
        case (r_md_state)
            MD_IDLE: if (w_md_start) w_md_state_next = MD_BUSY;
            MD_BUSY: begin
                if (r_md_cnt == CW'(XLEN-1)) begin
                    w_md_state_next = MD_IDLE;
                    w_md_done       = 1'b1;
                end
            end
            default: w_md_state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_md_state <= MD_IDLE;
            r_md_cnt   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_md_acc   <= '0;
            r_md_lo    <= '0;
            r_md_m     <= '0;
            r_md_dvd   <= '0;
            r_md_div   <= 1'b0;
            r_md_div0  <= 1'b0;
            r_md_neg_q <= 1'b0;
            r_md_neg_r <= 1'b0;
        end else begin
            r_md_state <= w_md_state_next;
            if (w_md_start) begin
                r_md_cnt   <= '0;
                r_md_acc   <= '0;
                r_md_lo    <= w_a_mag;
                r_md_m     <= w_b_mag;
                r_md_dvd   <= Ai;
                r_md_div   <= w_funct[1];
                r_md_div0  <= w_funct[1] && (Bi == '0);
                r_md_neg_q <= w_a_neg ^ w_b_neg;
                r_md_neg_r <= w_a_neg;
            end else if (w_md_busy) begin
                r_md_cnt <= r_md_cnt + 1'b1;
                r_md_acc <= w_acc_next;
                r_md_lo  <= w_lo_next;
            end
            if (w_md_done) begin
                r_hi <= w_hi_res;
                r_lo <= w_lo_res;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md: directed plan cases, then random instructions against an arithmetic
// reference model that tracks HI/LO and the MD busy window as a cycle countdown.
module tb_ex_stage_md;
    localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_MFHI = 6'h10, F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24;
    localparam logic [5:0] F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, flush, stall_o, out_valid, cond, ZFo, OFo;
    logic [31:0] IRi, NPCi, Ai, Bi, Immi, ALUo, Bo, IRo;

    logic        v64, st64, ov64, c64, zf64, of64;
    logic [31:0] ir64, iro64;
    logic [63:0] a64, b64, alu64, bo64;

    ex_stage_md #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .IRi(IRi), .NPCi(NPCi),
        .Ai(Ai), .Bi(Bi), .Immi(Immi), .stall_o(stall_o), .out_valid(out_valid), .cond(cond),
        .ALUo(ALUo), .ZFo(ZFo), .OFo(OFo), .Bo(Bo), .IRo(IRo)
    );

    ex_stage_md #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .flush(1'b0), .IRi(ir64), .NPCi(64'h0),
        .Ai(a64), .Bi(b64), .Immi(64'h0), .stall_o(st64), .out_valid(ov64), .cond(c64),
        .ALUo(alu64), .ZFo(zf64), .OFo(of64), .Bo(bo64), .IRo(iro64)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: architectural HI/LO, results pending from the MD unit, edges left until they land.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_rem;
    logic        last_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] f);
        return {6'h00, 20'h0, f};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'h0, imm};
    endfunction

    function automatic logic is_md(input logic [31:0] ir);
        return ir[31:26] == 6'h00 && (ir[5:0] == F_MULT || ir[5:0] == F_MULTU ||
                                      ir[5:0] == F_DIV  || ir[5:0] == F_DIVU);
    endfunction

    function automatic logic is_mf(input logic [31:0] ir);
        return ir[31:26] == 6'h00 && (ir[5:0] == F_MFHI || ir[5:0] == F_MFLO);
    endfunction

    function automatic void ref_alu(input logic [31:0] ir, npc, a, b, imm, hi, lo,
                                    output logic [31:0] alu, output logic c, output logic of);
        longint sa, sb, si, s;
        int     sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        si  = longint'($signed(imm));
        sh  = int'(ir[10:6]);
        alu = 32'h0; c = 1'b0; of = 1'b0;
        if (ir[31:26] == 6'h00) begin
            case (ir[5:0])
                F_ADD:  begin s = sa + sb; alu = a + b; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                F_SUB:  begin s = sa - sb; alu = a - b; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                F_ADDU: alu = a + b;
                F_SUBU: alu = a - b;
                F_AND:  alu = a & b;
                F_OR:   alu = a | b;
                F_XOR:  alu = a ^ b;
                F_NOR:  alu = ~(a | b);
                F_SLT:  alu = (sa < sb) ? 32'd1 : 32'd0;
                F_SLTU: alu = (a < b) ? 32'd1 : 32'd0;
                F_SLL:  alu = b * (32'd1 << sh);
                F_SRL:  alu = b / (32'd1 << sh);
                F_SRA:  begin s = sb >>> sh; alu = s[31:0]; end
                F_MFHI: alu = hi;
                F_MFLO: alu = lo;
                default: alu = 32'h0;
            endcase
        end else begin
            case (ir[31:26])
                OP_ADDI: begin s = sa + si; alu = a + imm; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                OP_ADDIU, OP_LW, OP_SW: alu = a + imm;
                OP_SLTI: alu = (sa < si) ? 32'd1 : 32'd0;
                OP_ANDI: alu = a & {16'h0, ir[15:0]};
                OP_ORI:  alu = a | {16'h0, ir[15:0]};
                OP_XORI: alu = a ^ {16'h0, ir[15:0]};
                OP_LUI:  alu = {ir[15:0], 16'h0};
                OP_BEQ:  begin c = (a == b); alu = npc + imm * 4; end
                OP_BNE:  begin c = (a != b); alu = npc + imm * 4; end
                OP_J, OP_JAL: begin c = 1'b1; alu = (npc & 32'hF000_0000) | ({6'h0, ir[25:0]} * 4); end
                default: alu = 32'h0;
            endcase
        end
    endfunction

    function automatic void ref_md(input logic [31:0] ir, a, b, output logic [31:0] hi, lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'h0; lo = 32'h0;
        case (ir[5:0])
            F_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            F_MULTU: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
            F_DIV: begin
                if (b == 32'h0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            default: begin
                if (b == 32'h0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    task automatic step(input logic v, input logic fl, input logic [31:0] ir, npc, a, b, imm,
                        input string tag);
        logic        e_stall, acc, e_c, e_of;
        logic [31:0] e_alu;
        in_valid = v; flush = fl; IRi = ir; NPCi = npc; Ai = a; Bi = b; Immi = imm;
        #1;
        e_stall = v && (m_rem > 0) && (is_md(ir) || is_mf(ir));
        last_stall = stall_o;
        chk({tag, ".stall"}, {63'h0, stall_o}, {63'h0, e_stall});
        acc = v && !e_stall && !fl;
        ref_alu(ir, npc, a, b, imm, m_hi, m_lo, e_alu, e_c, e_of);
        @(posedge clk);
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin m_hi = m_phi; m_lo = m_plo; end
        end
        if (acc && is_md(ir)) begin
            ref_md(ir, a, b, m_phi, m_plo);
            m_rem = 32;
        end
        #1;
        chk({tag, ".valid"}, {63'h0, out_valid}, {63'h0, acc});
        chk({tag, ".ir"},    {32'h0, IRo},  {32'h0, acc ? ir : 32'h0});
        chk({tag, ".cond"},  {63'h0, cond}, {63'h0, acc && e_c});
        chk({tag, ".alu"},   {32'h0, ALUo}, {32'h0, acc ? e_alu : 32'h0});
        chk({tag, ".zf"},    {63'h0, ZFo},  {63'h0, acc && (e_alu == 32'h0)});
        chk({tag, ".of"},    {63'h0, OFo},  {63'h0, acc && e_of});
        chk({tag, ".bo"},    {32'h0, Bo},   {32'h0, acc ? b : 32'h0});
        $display("txn %s ir=%h a=%h b=%h acc=%0d alu=%h cond=%0d", tag, ir, a, b, acc, ALUo, cond);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, "idle");
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        m_rem = 0; m_hi = 32'h0; m_lo = 32'h0;
        chk("rst.valid", {63'h0, out_valid}, 64'h0);
        chk("rst.alu",   {32'h0, ALUo}, 64'h0);
        chk("rst.ir",    {32'h0, IRo},  64'h0);
        chk("rst.flags", {61'h0, cond, ZFo, OFo}, 64'h0);
        chk("rst.bo",    {32'h0, Bo},   64'h0);
        rst = 1'b1;
        $display("txn reset cycles=%0d", n);
    endtask

    // Issue an MD op, poll MFLO until it is accepted, then read MFHI.
    task automatic md_then_read(input logic [5:0] f, input logic [31:0] a, b, exp_lo, exp_hi,
                                input string tag);
        int n;
        step(1'b1, 1'b0, mk_r(f), 32'h0, a, b, 32'h0, {tag, ".op"});
        n = 0;
        step(1'b1, 1'b0, mk_r(F_MFLO), 32'h0, 32'h0, 32'h0, 32'h0, {tag, ".mflo"});
        while (last_stall && n < 100) begin
            n++;
            step(1'b1, 1'b0, mk_r(F_MFLO), 32'h0, 32'h0, 32'h0, 32'h0, {tag, ".mflo"});
        end
        chk({tag, ".stalls"}, 64'(n), 64'd32);
        chk({tag, ".lo"}, {32'h0, ALUo}, {32'h0, exp_lo});
        step(1'b1, 1'b0, mk_r(F_MFHI), 32'h0, 32'h0, 32'h0, 32'h0, {tag, ".mfhi"});
        chk({tag, ".hi"}, {32'h0, ALUo}, {32'h0, exp_hi});
    endtask

    logic [5:0]  r_tab [20] = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT,
                               F_SLTU, F_SLL, F_SRL, F_SRA, F_MFHI, F_MFLO, F_MULT, F_MULTU,
                               F_DIV, F_DIVU, 6'h3F};
    logic [5:0]  i_tab [14] = '{OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
                               OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, 6'h3F};
    logic [31:0] edge_tab [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    function automatic logic [31:0] rnd_operand();
        if ($urandom_range(3) == 0) return edge_tab[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] ir, a, b, npc;
        int          n;
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
        IRi = 32'h0; NPCi = 32'h0; Ai = 32'h0; Bi = 32'h0; Immi = 32'h0;
        v64 = 1'b0; ir64 = 32'h0; a64 = 64'h0; b64 = 64'h0;
        m_rem = 0; m_hi = 32'h0; m_lo = 32'h0; m_phi = 32'h0; m_plo = 32'h0; last_stall = 1'b0;
        do_reset(2);

        step(1, 0, mk_r(F_ADD), 32'h0, 32'h1, 32'h3, 32'h0, "add");
        chk("add.plan", {32'h0, ALUo}, 64'h4);
        step(1, 0, mk_i(OP_ADDI, 16'h7), 32'h0, 32'h1, 32'h0, 32'h7, "addi");
        chk("addi.plan", {32'h0, ALUo}, 64'h8);
        step(1, 0, mk_r(F_ADD), 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, "addov");
        chk("addov.plan", {31'h0, OFo, ALUo}, {31'h0, 1'b1, 32'h8000_0000});
        step(1, 0, mk_r(F_SUB), 32'h0, 32'h5, 32'h5, 32'h0, "subz");
        chk("subz.plan", {63'h0, ZFo}, 64'h1);
        step(1, 0, mk_r(F_ADDU), 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, "addu");
        chk("addu.plan", {63'h0, OFo}, 64'h0);
        step(1, 0, mk_i(OP_BEQ, 16'h4), 32'h100, 32'h9, 32'h9, 32'h4, "beq");
        chk("beq.plan", {31'h0, cond, ALUo}, {31'h0, 1'b1, 32'h110});
        step(1, 0, mk_i(OP_BNE, 16'h4), 32'h100, 32'h9, 32'h9, 32'h4, "bne");
        chk("bne.plan", {63'h0, cond}, 64'h0);
        step(1, 0, {OP_J, 26'h40}, 32'h1000_0004, 32'h0, 32'h0, 32'h0, "j");
        chk("j.plan", {31'h0, cond, ALUo}, {31'h0, 1'b1, 32'h1000_0100});
        step(1, 1, mk_r(F_ADD), 32'h0, 32'h1, 32'h3, 32'h0, "flush");
        chk("flush.plan", {31'h0, out_valid, IRo}, 64'h0);

        md_then_read(F_MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "mult");
        md_then_read(F_DIV,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div");
        md_then_read(F_DIVU, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h5, "div0");
        md_then_read(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, "divovf");

        step(1, 0, mk_r(F_MULTU), 32'h0, 32'h1234, 32'h10, 32'h0, "mulbg");
        step(1, 0, mk_r(F_ADD), 32'h0, 32'h20, 32'h22, 32'h0, "busyadd");
        chk("busyadd.plan", {32'h0, ALUo}, 64'h42);
        step(1, 1, mk_r(F_MFHI), 32'h0, 32'h0, 32'h0, 32'h0, "stallflush");
        idle(32);

        step(1, 0, mk_r(F_MULT), 32'h0, 32'h3, 32'h5, 32'h0, "mulrst");
        idle(9);
        do_reset(1);
        step(1, 0, mk_r(F_MFLO), 32'h0, 32'h0, 32'h0, 32'h0, "postrst");
        chk("postrst.plan", {31'h0, stall_o, ALUo}, 64'h0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(1) == 0) ir = {6'h00, 15'($urandom), 5'($urandom), r_tab[$urandom_range(19)]};
            else                        ir = {i_tab[$urandom_range(13)], 26'($urandom)};
            a   = rnd_operand();
            b   = ($urandom_range(3) == 0) ? a : rnd_operand();
            npc = $urandom;
            step($urandom_range(9) != 0, $urandom_range(9) == 0, ir, npc, a, b,
                 {{16{ir[15]}}, ir[15:0]}, $sformatf("rnd%0d", i));
        end
        idle(40);

        v64 = 1'b1; ir64 = mk_r(F_MULTU); a64 = 64'h1 << 40; b64 = 64'h1 << 40;
        @(posedge clk); #1;
        chk("x64.mul", {ov64, alu64[62:0]}, {1'b1, 63'h0});
        ir64 = mk_r(F_MFHI); a64 = 64'h0; b64 = 64'h0;
        #1;
        n = 0;
        while (st64 && n < 200) begin @(posedge clk); #1; n++; end
        chk("x64.stalls", 64'(n), 64'd64);
        @(posedge clk); #1;
        chk("x64.hi", alu64, 64'h10000);
        ir64 = mk_r(F_MFLO);
        @(posedge clk); #1;
        chk("x64.lo", {zf64, alu64[62:0]}, {1'b1, 63'h0});
        ir64 = mk_r(F_ADD); a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'h1;
        @(posedge clk); #1;
        chk("x64.addov", {of64, alu64[62:0]}, {1'b1, 63'h0});
        v64 = 1'b0;
        $display("txn x64 done stalls=%0d", n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
